// File: rtl/dm_unit_pkg.sv
// ---------------------------------------------------------------------------
// dm_unit_pkg
// Shared definitions for the data-memory stage:
//   - DMType access codes as driven by the CPU's EX/MEM register
//   - sweep FSM state encoding
//   - access-size classification and signedness helpers
// No ports (package).
// ---------------------------------------------------------------------------
package dm_unit_pkg;

    localparam logic [2:0] DM_WORD          = 3'b000;
    localparam logic [2:0] DM_HALFWORD      = 3'b001;
    localparam logic [2:0] DM_HALFWORD_UNS  = 3'b010;
    localparam logic [2:0] DM_BYTE          = 3'b011;
    localparam logic [2:0] DM_BYTE_UNS      = 3'b100;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } dm_state_e;

    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2
    } dm_size_e;

    // Unused codes 101-111 fall through to a word access.
    function automatic dm_size_e dmSize(input logic [2:0] dmType);
        dm_size_e sz;
        case (dmType)
            DM_HALFWORD, DM_HALFWORD_UNS: sz = SZ_HALF;
            DM_BYTE, DM_BYTE_UNS:         sz = SZ_BYTE;
            default:                      sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic dmSigned(input logic [2:0] dmType);
        return (dmType == DM_HALFWORD) || (dmType == DM_BYTE);
    endfunction

endpackage

// File: rtl/dm_unit_lane_fmt.sv
// ---------------------------------------------------------------------------
// dm_lane_fmt
// Purely combinational byte-lane formatter for the data memory.
// Given the access type and the low address bits it produces the lane
// enables, the store word merged into the current array word, the
// extended load value and the misalignment indication.
// Ports:
//   i_dmType     [2:0]   access type code
//   i_addrLo     [1:0]   byte offset within the word
//   i_din        [31:0]  right-aligned store data
//   i_rdWord     [31:0]  current contents of the addressed word
//   o_byteEn     [3:0]   lanes written by a store
//   o_wrWord     [31:0]  i_rdWord with the enabled lanes replaced
//   o_ldData     [31:0]  selected and sign/zero-extended load value
//   o_misaligned         access violates the alignment rule for its size
// ---------------------------------------------------------------------------
module dm_lane_fmt
    import dm_unit_pkg::*;
(
    input  logic [2:0]  i_dmType,
    input  logic [1:0]  i_addrLo,
    input  logic [31:0] i_din,
    input  logic [31:0] i_rdWord,
    output logic [3:0]  o_byteEn,
    output logic [31:0] o_wrWord,
    output logic [31:0] o_ldData,
    output logic        o_misaligned
);

    dm_size_e    w_size;
    logic        w_signed;
    logic [31:0] w_laneData;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_size   = dmSize(i_dmType);
    assign w_signed = dmSigned(i_dmType);

    // Store data is replicated across every lane it could land in, so the
    // byte enables alone decide which copy ends up in the array.
    always_comb begin
        o_byteEn     = 4'b0000;
        w_laneData   = i_din;
        o_ldData     = i_rdWord;
        o_misaligned = 1'b0;
        w_half       = i_addrLo[1] ? i_rdWord[31:16] : i_rdWord[15:0];
        case (i_addrLo)
            2'd1:    w_byte = i_rdWord[15:8];
            2'd2:    w_byte = i_rdWord[23:16];
            2'd3:    w_byte = i_rdWord[31:24];
            default: w_byte = i_rdWord[7:0];
        endcase
        case (w_size)
            SZ_HALF: begin
                o_byteEn     = i_addrLo[1] ? 4'b1100 : 4'b0011;
                w_laneData   = {i_din[15:0], i_din[15:0]};
                o_ldData     = w_signed ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
                o_misaligned = i_addrLo[0];
            end
            SZ_BYTE: begin
                o_byteEn     = 4'b0001 << i_addrLo;
                w_laneData   = {4{i_din[7:0]}};
                o_ldData     = w_signed ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
                o_misaligned = 1'b0;
            end
            default: begin
                o_byteEn     = 4'b1111;
                w_laneData   = i_din;
                o_ldData     = i_rdWord;
                o_misaligned = (i_addrLo != 2'b00);
            end
        endcase
    end

    // Lane merge: untouched lanes keep the array's current bytes.
    always_comb begin
        o_wrWord = i_rdWord;
        for (int i = 0; i < 4; i++) begin
            if (o_byteEn[i]) begin
                o_wrWord[8*i +: 8] = w_laneData[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dm_unit.sv
// ---------------------------------------------------------------------------
// dm_unit
// Data-memory stage after the EX/MEM register. Asynchronous reads,
// synchronous byte-lane writes, sign/zero-extended loads, a sticky
// misaligned-access flag, and a post-reset sweep that zeroes the array
// while holding the CPU off with busy.
// Ports:
//   clk                 clock, rising edge
//   rst                 asynchronous active-high reset
//   mem_w               store request
//   DMType       [2:0]  access type
//   addr         [31:0] byte address
//   din          [31:0] right-aligned store data
//   err_clr             clears the sticky error
//   dout         [31:0] extended load data (combinational)
//   busy                clear sweep in progress
//   misalign_err        sticky misaligned-access flag
//   err_addr     [31:0] address of first misaligned access since clear
// ---------------------------------------------------------------------------
module dm_unit
    import dm_unit_pkg::*;
#(
    parameter int DEPTH = 128
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_w,
    input  logic [2:0]  DMType,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic        err_clr,
    output logic [31:0] dout,
    output logic        busy,
    output logic        misalign_err,
    output logic [31:0] err_addr
);

    localparam int AW = $clog2(DEPTH);

    dm_state_e   r_state;
    dm_state_e   w_stateNext;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idxNext;
    logic [31:0] r_mem [DEPTH];

    logic [AW-1:0] w_idx;
    logic        w_inRange;
    logic [31:0] w_rdWord;
    logic [3:0]  w_byteEn;
    logic [31:0] w_wrWord;
    logic [31:0] w_ldData;
    logic        w_misaligned;
    logic        w_checkAlign;
    logic        w_misErr;
    logic        w_storeEn;

    assign w_idx     = addr[AW+1:2];
    assign w_inRange = (addr[31:AW+2] == '0);
    assign w_rdWord  = w_inRange ? r_mem[w_idx] : 32'h0000_0000;
    assign busy      = (r_state == ST_CLEAR);

    dm_lane_fmt u_laneFmt (
        .i_dmType     (DMType),
        .i_addrLo     (addr[1:0]),
        .i_din        (din),
        .i_rdWord     (w_rdWord),
        .o_byteEn     (w_byteEn),
        .o_wrWord     (w_wrWord),
        .o_ldData     (w_ldData),
        .o_misaligned (w_misaligned)
    );

    // A pipeline bubble presents addr=0 with mem_w=0; since address 0 is
    // aligned for every size, only non-zero load addresses need checking.
    assign w_checkAlign = mem_w | (addr != 32'h0000_0000);
    assign w_misErr     = ~busy & w_checkAlign & w_misaligned;
    assign w_storeEn    = ~busy & mem_w & w_inRange & ~w_misaligned;
    assign dout         = (busy | w_misaligned | ~w_inRange) ? 32'h0000_0000 : w_ldData;

    // Sweep FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_idx   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_idx   <= w_idxNext;
        end
    end

    // Sweep FSM next state: walk every word once, then park in IDLE.
    always_comb begin
        w_stateNext = r_state;
        w_idxNext   = r_idx;
        case (r_state)
            ST_CLEAR: begin
                w_idxNext = r_idx + 1'b1;
                if (r_idx == AW'(DEPTH - 1)) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Array write port: the sweep owns it while clearing, the CPU afterwards.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_idx] <= 32'h0000_0000;
        end else if (w_storeEn) begin
            r_mem[w_idx] <= w_wrWord;
        end
    end

    // Sticky error: a new misaligned access outranks a simultaneous clear,
    // and the captured address is only replaced when the flag is not held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err <= 1'b0;
            err_addr     <= 32'h0000_0000;
        end else if (w_misErr) begin
            misalign_err <= 1'b1;
            if (!misalign_err || err_clr) begin
                err_addr <= addr;
            end
        end else if (err_clr) begin
            misalign_err <= 1'b0;
            err_addr     <= 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_dm_unit.sv
// ---------------------------------------------------------------------------
// tb_dm_unit
// Scoreboarded bench for dm_unit: directed scenarios plus randomized
// traffic against a byte-array reference model.
// ---------------------------------------------------------------------------
module tb_dm_unit;

    localparam int DEPTH = 128;
    localparam int BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_w;
    logic [2:0]  DMType;
    logic [31:0] addr;
    logic [31:0] din;
    logic        err_clr;
    logic [31:0] dout;
    logic        busy;
    logic        misalign_err;
    logic [31:0] err_addr;

    typedef struct {
        logic [31:0] dout;
        logic        chkDout;
        logic        err;
        logic [31:0] errAddr;
        int          id;
    } exp_t;

    exp_t        expQ[$];
    logic [7:0]  mMem [BYTES];
    logic        mErr;
    logic [31:0] mErrAddr;
    logic        tbValid = 1'b0;
    int          opCount = 0;
    int          errors  = 0;
    int          checks  = 0;

    dm_unit #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_w        (mem_w),
        .DMType       (DMType),
        .addr         (addr),
        .din          (din),
        .err_clr      (err_clr),
        .dout         (dout),
        .busy         (busy),
        .misalign_err (misalign_err),
        .err_addr     (err_addr)
    );

    always #5 clk = ~clk;

    // Reference model: plain byte array, sizes and alignment from the access rules.
    function automatic int accSize(input logic [2:0] t);
        if (t == 3'b001 || t == 3'b010) return 2;
        if (t == 3'b011 || t == 3'b100) return 1;
        return 4;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] t, input logic [31:0] a);
        int          sz;
        logic [31:0] v;
        sz = accSize(t);
        v  = 32'h0;
        if ((a % sz) != 0 || a >= BYTES) return 32'h0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mMem[a + i];
        if (t == 3'b001) v = {{16{v[15]}}, v[15:0]};
        if (t == 3'b011) v = {{24{v[7]}}, v[7:0]};
        return v;
    endfunction

    task automatic modelUpdate(input logic w, input logic [2:0] t, input logic [31:0] a,
                               input logic [31:0] d, input logic clr);
        int sz;
        sz = accSize(t);
        if ((w || a != 0) && (a % sz) != 0) begin
            if (!mErr || clr) mErrAddr = a;
            mErr = 1'b1;
        end else if (clr) begin
            mErr     = 1'b0;
            mErrAddr = 32'h0;
        end
        if (w && (a % sz) == 0 && a < BYTES)
            for (int i = 0; i < sz; i++) mMem[a + i] = d[8*i +: 8];
    endtask

    task automatic modelReset();
        for (int i = 0; i < BYTES; i++) mMem[i] = 8'h00;
        mErr     = 1'b0;
        mErrAddr = 32'h0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one access; the expected response is queued for the monitor.
    task automatic applyStimulus(input logic w, input logic [2:0] t, input logic [31:0] a,
                                 input logic [31:0] d, input logic clr,
                                 input logic useExp, input logic [31:0] expD);
        exp_t e;
        @(posedge clk); #1;
        mem_w   = w;
        DMType  = t;
        addr    = a;
        din     = d;
        err_clr = clr;
        tbValid = 1'b1;
        e.dout    = useExp ? expD : modelLoad(t, a);
        e.chkDout = !w;
        e.err     = mErr;
        e.errAddr = mErrAddr;
        e.id      = opCount++;
        expQ.push_back(e);
        modelUpdate(w, t, a, d, clr);
    endtask

    task automatic applyIdle();
        @(posedge clk); #1;
        tbValid = 1'b0;
        mem_w   = 1'b0;
        DMType  = 3'b000;
        addr    = 32'h0;
        din     = 32'h0;
        err_clr = 1'b0;
    endtask

    // Count cycles of busy after reset release; optionally poke the DUT mid-sweep.
    task automatic waitSweep(input logic poke);
        int cycles;
        cycles = 0;
        while (busy && cycles <= 2 * DEPTH) begin
            @(posedge clk); #1;
            cycles++;
            if (poke && cycles == 5) begin
                mem_w = 1'b1; DMType = 3'b000; addr = 32'h10; din = 32'hDEAD_BEEF;
            end
            if (poke && cycles == 6) begin
                mem_w = 1'b0;
                checkOutput("busyLoadZero", dout, 32'h0);
                mem_w = 1'b1; addr = 32'h11;
            end
            if (poke && cycles == 7) begin
                mem_w = 1'b0; addr = 32'h0;
            end
        end
        checkOutput("sweepLen", cycles, DEPTH);
    endtask

    // Monitor: each presented access is compared against the queued expectation.
    always @(negedge clk) begin
        if (tbValid) begin
            if (expQ.size() == 0) begin
                checkOutput("queueUnderflow", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("busyIdle", {31'h0, busy}, 32'h0);
                if (e.chkDout) checkOutput($sformatf("dout#%0d", e.id), dout, e.dout);
                checkOutput($sformatf("err#%0d", e.id), {31'h0, misalign_err}, {31'h0, e.err});
                checkOutput($sformatf("errAddr#%0d", e.id), err_addr, e.errAddr);
            end
        end
    end

    initial begin
        rst = 1'b1; mem_w = 1'b0; DMType = 3'b000; addr = 32'h0; din = 32'h0; err_clr = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetBusy", {31'h0, busy}, 32'h1);
        checkOutput("resetErr", {31'h0, misalign_err}, 32'h0);
        checkOutput("resetErrAddr", err_addr, 32'h0);
        checkOutput("resetDout", dout, 32'h0);

        // Sweep with stores (aligned and misaligned) attempted while busy.
        @(negedge clk); rst = 1'b0;
        waitSweep(1'b1);
        checkOutput("busyNoErr", {31'h0, misalign_err}, 32'h0);
        applyStimulus(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 1'b1, 32'h0);
        applyStimulus(1'b0, 3'b000, 32'h1FC, 32'h0, 1'b0, 1'b1, 32'h0);

        // Byte merge into a word, signed/unsigned byte loads.
        applyStimulus(1'b1, 3'b000, 32'h10, 32'h8000_00FF, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 3'b011, 32'h12, 32'h0000_00AB, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 1'b1, 32'h80AB_00FF);
        applyStimulus(1'b0, 3'b011, 32'h13, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF80);
        applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 1'b1, 32'h0000_0080);

        // Halfword store in the upper half and its loads.
        applyStimulus(1'b1, 3'b001, 32'h22, 32'h0000_F00D, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'b001, 32'h22, 32'h0, 1'b0, 1'b1, 32'hFFFF_F00D);
        applyStimulus(1'b0, 3'b010, 32'h22, 32'h0, 1'b0, 1'b1, 32'h0000_F00D);
        applyStimulus(1'b0, 3'b000, 32'h20, 32'h0, 1'b0, 1'b1, 32'hF00D_0000);

        // Misalignment: first address sticks, clear loses to a new error.
        applyStimulus(1'b1, 3'b000, 32'h21, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'b000, 32'h20, 32'h0, 1'b0, 1'b1, 32'hF00D_0000);
        applyStimulus(1'b0, 3'b001, 32'h33, 32'h0, 1'b0, 1'b1, 32'h0);
        applyStimulus(1'b1, 3'b001, 32'h41, 32'h0000_5555, 1'b1, 1'b0, 32'h0);
        applyIdle();
        #1;
        checkOutput("clrVsNewErr", {31'h0, misalign_err}, 32'h1);
        checkOutput("clrVsNewAddr", err_addr, 32'h41);

        // Out-of-range store/load, and no aliasing onto word 0.
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 3'b000, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 3'b000, BYTES, 32'hCAFE_BABE, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'b000, BYTES, 32'h0, 1'b0, 1'b1, 32'h0);
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
        applyIdle();
        #1;
        checkOutput("oorNoErr", {31'h0, misalign_err}, 32'h0);

        // Randomized traffic, biased toward a small window for read-after-write hits.
        for (int n = 0; n < 400; n++) begin
            int          r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'h0;
            else if (r == 1) a = BYTES + $urandom_range(0, 255);
            else if (r < 6)  a = $urandom_range(0, 63);
            else             a = $urandom_range(0, BYTES - 1);
            applyStimulus(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), a, $urandom,
                          ($urandom_range(0, 7) == 0), 1'b0, 32'h0);
        end
        applyIdle();

        // Reset in the middle of the sweep restarts it from word 0.
        applyStimulus(1'b1, 3'b000, 32'h40, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0);
        applyIdle();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        modelReset();
        checkOutput("midSweepBusy", {31'h0, busy}, 32'h1);
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        waitSweep(1'b0);
        applyStimulus(1'b0, 3'b000, 32'h40, 32'h0, 1'b0, 1'b1, 32'h0);
        applyStimulus(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 1'b1, 32'h0);
        applyIdle();
        @(posedge clk); #1;
        checkOutput("queueDrained", expQ.size(), 32'h0);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
